min_seq_ctrl: RTL

MIN_SEQ_CTRL -- requirements
Module: min_seq_ctrl

---
 rtl/min_pkg.sv | 11 +
 rtl/min_seq_ctrl_if.sv | 28 ++
 rtl/min_acc.sv | 36 +++
 rtl/min_seq_ctrl.sv | 75 +++++++
 4 files changed

// File: rtl/min_pkg.sv
// Shared constants for the burst-minimum sequencer: default widths and FSM encoding.
package min_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned LW_DEF = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/min_seq_ctrl_if.sv
// Handshake bundle for min_seq_ctrl: burst request, sample stream, result stream.
interface min_seq_ctrl_if import min_pkg::*; #(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned LW = LW_DEF
) ();

  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_min;
  logic [LW-1:0] out_idx;
  logic          out_ready;
  logic          busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_idx, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_idx, busy
  );

endinterface

// File: rtl/min_acc.sv
// Registered compare-and-hold: tracks the running minimum and its index within a burst.
module min_acc import min_pkg::*; #(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          update,
  input  logic [DW-1:0] data,
  input  logic [LW-1:0] idx_in,
  output logic [DW-1:0] min_val,
  output logic [LW-1:0] min_idx
);

  logic [DW-1:0] min_q;
  logic [LW-1:0] idx_q;

  // Strict compare keeps the earliest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      min_q <= data;
      idx_q <= idx_in;
    end else if (update && (data < min_q)) begin
      min_q <= data;
      idx_q <= idx_in;
    end
  end

  assign min_val = min_q;
  assign min_idx = idx_q;

endmodule

// File: rtl/min_seq_ctrl.sv
// Burst sequencer: accepts len samples, then presents their minimum and its position.
module min_seq_ctrl import min_pkg::*; #(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  min_seq_ctrl_if.slave  bus
);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          accept;
  logic          last;

  assign accept = bus.in_valid && (state_q == StRun);
  assign last   = accept && (cnt_q == (len_q - LW'(1)));

  assign bus.in_ready  = (state_q == StRun);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.len != '0)) begin
          len_d   = bus.len;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q + LW'(1);
          if (last) state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  min_acc #(
    .DW (DW),
    .LW (LW)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && (cnt_q == '0)),
    .update  (accept && (cnt_q != '0)),
    .data    (bus.in_data),
    .idx_in  (cnt_q),
    .min_val (bus.out_min),
    .min_idx (bus.out_idx)
  );

endmodule
